// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the unified-memory port arbiter.
package mem_arb_pkg;

    localparam int DEF_ADDR_W = 30;
    localparam int DEF_DATA_W = 32;

    // Arbiter sequencing: grant, wait for memory, one-cycle ack, back to idle
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_BUSY = 2'd2,
        DONE   = 2'd3
    } arb_state_t;

    // Which requester owns the memory bus during a BUSY state
    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } arb_owner_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester-side and memory-side signals around the arbiter.
//
// Handshake: a requester (IF_Read, or D_Read / nonzero D_Write) raises its
// request and holds it, address and data stable until its Ack pulses for one
// cycle. The arbiter raises Mem_Req and holds every Mem_* output stable until
// memory returns a one-cycle Mem_Ack, which may come in the first Mem_Req
// cycle; Mem_DataIn is sampled on that cycle.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 30,
    parameter int DATA_W = 32
);
    localparam int BE_W = DATA_W / 8;

    logic              IF_Read;
    logic [ADDR_W-1:0] IF_Address;
    logic [DATA_W-1:0] IF_DataOut;
    logic              IF_Ack;

    logic              D_Read;
    logic [BE_W-1:0]   D_Write;
    logic [ADDR_W-1:0] D_Address;
    logic [DATA_W-1:0] D_DataIn;
    logic [DATA_W-1:0] D_DataOut;
    logic              D_Ack;
    logic              DataMemStall;

    logic              Mem_Req;
    logic [BE_W-1:0]   Mem_We;
    logic [ADDR_W-1:0] Mem_Address;
    logic [DATA_W-1:0] Mem_DataOut;
    logic [DATA_W-1:0] Mem_DataIn;
    logic              Mem_Ack;

    // Arbiter view
    modport slave (
        input  IF_Read, IF_Address, D_Read, D_Write, D_Address, D_DataIn,
               Mem_DataIn, Mem_Ack,
        output IF_DataOut, IF_Ack, D_DataOut, D_Ack, DataMemStall,
               Mem_Req, Mem_We, Mem_Address, Mem_DataOut
    );

    // Pipeline stages plus memory view
    modport master (
        output IF_Read, IF_Address, D_Read, D_Write, D_Address, D_DataIn,
               Mem_DataIn, Mem_Ack,
        input  IF_DataOut, IF_Ack, D_DataOut, D_Ack, DataMemStall,
               Mem_Req, Mem_We, Mem_Address, Mem_DataOut
    );

endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and data access.
// Data side has fixed priority; each access is request -> grant -> Mem_Ack ->
// one-cycle requester ack, followed by a DONE cycle that ignores requests so
// the requester can drop its request without triggering a duplicate access.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                 clock,
    input  logic                 reset,
    mem_port_arbiter_if.slave    bus,
    output arb_state_t           o_state
);

    localparam int BE_W = DATA_W / 8;

    arb_state_t        r_state;
    logic              r_mem_req;
    logic [BE_W-1:0]   r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_if_ack;
    logic              r_d_ack;
    logic [DATA_W-1:0] r_if_data;
    logic [DATA_W-1:0] r_d_data;

    logic              w_d_pending;
    arb_owner_t        w_owner;

    // A store counts as a data request even without D_Read
    assign w_d_pending = bus.D_Read | (|bus.D_Write);
    assign w_owner     = (r_state == D_BUSY) ? OWN_D : OWN_I;

    // Stall the data side until the cycle its ack is visible
    assign bus.DataMemStall = w_d_pending & ~r_d_ack;

    assign bus.Mem_Req     = r_mem_req;
    assign bus.Mem_We      = r_mem_we;
    assign bus.Mem_Address = r_mem_addr;
    assign bus.Mem_DataOut = r_mem_wdata;
    assign bus.IF_Ack      = r_if_ack;
    assign bus.IF_DataOut  = r_if_data;
    assign bus.D_Ack       = r_d_ack;
    assign bus.D_DataOut   = r_d_data;
    assign o_state         = r_state;

    // Arbitration FSM with all memory and requester outputs registered
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_mem_req   <= 1'b0;
            r_mem_we    <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_ack    <= 1'b0;
            r_d_ack     <= 1'b0;
            r_if_data   <= '0;
            r_d_data    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    // MEM holds the older instruction, so data wins ties
                    if (w_d_pending) begin
                        r_state     <= D_BUSY;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= bus.D_Write;
                        r_mem_addr  <= bus.D_Address;
                        r_mem_wdata <= bus.D_DataIn;
                    end else if (bus.IF_Read) begin
                        r_state     <= I_BUSY;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= '0;
                        r_mem_addr  <= bus.IF_Address;
                        r_mem_wdata <= '0;
                    end
                end
                I_BUSY, D_BUSY: begin
                    // No preemption: hold Mem_* until memory completes
                    if (bus.Mem_Ack) begin
                        r_state   <= DONE;
                        r_mem_req <= 1'b0;
                        r_mem_we  <= '0;
                        if (w_owner == OWN_D) begin
                            r_d_data <= bus.Mem_DataIn;
                            r_d_ack  <= 1'b1;
                        end else begin
                            r_if_data <= bus.Mem_DataIn;
                            r_if_ack  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    // Requester sees its ack now; requests are ignored here
                    r_if_ack <= 1'b0;
                    r_d_ack  <= 1'b0;
                    r_state  <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a table of single accesses plus
// hand-written sequences for priority, streaming, reset and spurious acks.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    logic       clock;
    logic       reset;
    arb_state_t dbg_state;

    int n_cmp;
    int n_err;

    mem_port_arbiter_if #(.ADDR_W(30), .DATA_W(32)) bus ();

    mem_port_arbiter #(.ADDR_W(30), .DATA_W(32)) dut (
        .clock   (clock),
        .reset   (reset),
        .bus     (bus.slave),
        .o_state (dbg_state)
    );

    // Clock and watchdog
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic        is_d;
        logic        d_read;
        logic [3:0]  d_we;
        logic [29:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          w;
        logic [3:0]  exp_we;
        logic [29:0] exp_addr;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        bus.IF_Read    = 1'b0;
        bus.IF_Address = '0;
        bus.D_Read     = 1'b0;
        bus.D_Write    = '0;
        bus.D_Address  = '0;
        bus.D_DataIn   = '0;
        bus.Mem_Ack    = 1'b0;
        bus.Mem_DataIn = '0;
    endtask

    // One complete access from IDLE with a w-cycle memory
    task automatic run_vec(input vec_t v, input int idx);
        int req_cnt;
        int stall_bad;
        int stable_bad;
        clear_inputs();
        if (v.is_d) begin
            bus.D_Read    = v.d_read;
            bus.D_Write   = v.d_we;
            bus.D_Address = v.addr;
            bus.D_DataIn  = v.wdata;
        end else begin
            bus.IF_Read    = 1'b1;
            bus.IF_Address = v.addr;
        end
        #1;
        check($sformatf("v%0d stall_pre", idx), 64'(bus.DataMemStall), 64'(v.is_d));
        tick();
        check($sformatf("v%0d mem_req", idx), 64'(bus.Mem_Req), 64'd1);
        check($sformatf("v%0d mem_we", idx), 64'(bus.Mem_We), 64'(v.exp_we));
        check($sformatf("v%0d mem_addr", idx), 64'(bus.Mem_Address), 64'(v.exp_addr));
        check($sformatf("v%0d mem_wdata", idx), 64'(bus.Mem_DataOut), 64'(v.exp_wdata));
        req_cnt = 0; stall_bad = 0; stable_bad = 0;
        for (int i = 0; i <= v.w; i++) begin
            if (bus.Mem_Req === 1'b1) req_cnt++;
            if (bus.Mem_Address !== v.exp_addr || bus.Mem_We !== v.exp_we ||
                bus.Mem_DataOut !== v.exp_wdata) stable_bad++;
            if (bus.IF_Ack !== 1'b0 || bus.D_Ack !== 1'b0) stable_bad++;
            if (bus.DataMemStall !== v.is_d) stall_bad++;
            bus.Mem_Ack    = (i == v.w);
            bus.Mem_DataIn = (i == v.w) ? v.rdata : (32'h0BAD0BAD ^ 32'(i));
            tick();
        end
        bus.Mem_Ack    = 1'b0;
        bus.Mem_DataIn = 32'h5555AAAA;
        check($sformatf("v%0d req_cycles", idx), 64'(req_cnt), 64'(v.w + 1));
        check($sformatf("v%0d busy_stable", idx), 64'(stable_bad), 64'd0);
        check($sformatf("v%0d busy_stall", idx), 64'(stall_bad), 64'd0);
        check($sformatf("v%0d mem_req_off", idx), 64'(bus.Mem_Req), 64'd0);
        check($sformatf("v%0d mem_we_off", idx), 64'(bus.Mem_We), 64'd0);
        check($sformatf("v%0d stall_at_ack", idx), 64'(bus.DataMemStall), 64'd0);
        if (v.is_d) begin
            check($sformatf("v%0d d_ack", idx), 64'(bus.D_Ack), 64'd1);
            check($sformatf("v%0d if_ack_quiet", idx), 64'(bus.IF_Ack), 64'd0);
            check($sformatf("v%0d d_data", idx), 64'(bus.D_DataOut), 64'(v.exp_rdata));
        end else begin
            check($sformatf("v%0d if_ack", idx), 64'(bus.IF_Ack), 64'd1);
            check($sformatf("v%0d d_ack_quiet", idx), 64'(bus.D_Ack), 64'd0);
            check($sformatf("v%0d if_data", idx), 64'(bus.IF_DataOut), 64'(v.exp_rdata));
        end
        clear_inputs();
        tick();
        check($sformatf("v%0d acks_drop", idx), 64'({bus.IF_Ack, bus.D_Ack}), 64'd0);
        check($sformatf("v%0d idle", idx), 64'(dbg_state), 64'(IDLE));
        check($sformatf("v%0d no_dup_req", idx), 64'(bus.Mem_Req), 64'd0);
        if (v.is_d)
            check($sformatf("v%0d d_data_hold", idx), 64'(bus.D_DataOut), 64'(v.exp_rdata));
        else
            check($sformatf("v%0d if_data_hold", idx), 64'(bus.IF_DataOut), 64'(v.exp_rdata));
    endtask

    initial begin
        int bad;
        int ack_cnt;
        int req_cnt;
        int dup_bad;
        logic prev_ack;
        int gap;

        n_cmp = 0;
        n_err = 0;

        //            is_d d_rd d_we   addr          wdata         rdata         w  exp_we exp_addr      exp_wdata     exp_rdata
        vecs[0] = '{1'b0, 1'b0, 4'h0, 30'h0000100, 32'h00000000, 32'h8C220004, 2, 4'h0, 30'h0000100, 32'h00000000, 32'h8C220004};
        vecs[1] = '{1'b1, 1'b0, 4'h3, 30'h0000040, 32'hDEADBEEF, 32'h11112222, 1, 4'h3, 30'h0000040, 32'hDEADBEEF, 32'h11112222};
        vecs[2] = '{1'b1, 1'b1, 4'h0, 30'h3FFFFFFF, 32'h00000000, 32'hCAFEF00D, 0, 4'h0, 30'h3FFFFFFF, 32'h00000000, 32'hCAFEF00D};
        vecs[3] = '{1'b1, 1'b1, 4'hF, 30'h0000155, 32'h12345678, 32'hA5A5A5A5, 3, 4'hF, 30'h0000155, 32'h12345678, 32'hA5A5A5A5};
        vecs[4] = '{1'b0, 1'b0, 4'h0, 30'h0000000, 32'h00000000, 32'hFFFFFFFF, 0, 4'h0, 30'h0000000, 32'h00000000, 32'hFFFFFFFF};

        // Reset values while reset is held
        reset = 1'b1;
        clear_inputs();
        #12;
        check("rst state", 64'(dbg_state), 64'(IDLE));
        check("rst mem_outs", {bus.Mem_Req, 4'(bus.Mem_We), 30'(bus.Mem_Address)}, 64'd0);
        check("rst mem_wdata", 64'(bus.Mem_DataOut), 64'd0);
        check("rst acks", 64'({bus.IF_Ack, bus.D_Ack}), 64'd0);
        check("rst data", {bus.IF_DataOut, bus.D_DataOut}, 64'd0);
        #1 reset = 1'b0;
        tick();

        // Spurious Mem_Ack while idle, starting in the cycle after reset
        bad = 0;
        bus.Mem_Ack    = 1'b1;
        bus.Mem_DataIn = 32'h77777777;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus.IF_Ack !== 1'b0 || bus.D_Ack !== 1'b0 || dbg_state !== IDLE) bad++;
            if (bus.Mem_Req !== 1'b0 || bus.Mem_We !== 4'h0 || bus.Mem_Address !== 30'h0 ||
                bus.Mem_DataOut !== 32'h0) bad++;
        end
        bus.Mem_Ack = 1'b0;
        check("spurious ack", 64'(bad), 64'd0);
        check("spurious data", {bus.IF_DataOut, bus.D_DataOut}, 64'd0);

        // Table of single accesses
        for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

        // Simultaneous IF and D reads with w=0: data first, IF 3 cycles later
        clear_inputs();
        bus.IF_Read    = 1'b1;
        bus.IF_Address = 30'h0000200;
        bus.D_Read     = 1'b1;
        bus.D_Address  = 30'h0000300;
        tick();
        check("prio grant_d", 64'(dbg_state), 64'(D_BUSY));
        check("prio addr_d", 64'(bus.Mem_Address), 64'h300);
        bus.Mem_Ack    = 1'b1;
        bus.Mem_DataIn = 32'h0D0D0D0D;
        tick();
        bus.Mem_Ack = 1'b0;
        bus.D_Read  = 1'b0;
        check("prio d_ack", 64'({bus.D_Ack, bus.IF_Ack}), 64'b10);
        check("prio d_data", 64'(bus.D_DataOut), 64'h0D0D0D0D);
        gap = 0;
        bad = 0;
        for (int i = 0; i < 6 && bus.IF_Ack !== 1'b1; i++) begin
            if (bus.Mem_Req === 1'b1 && bus.Mem_Address !== 30'h0000200) bad++;
            bus.Mem_Ack    = bus.Mem_Req;
            bus.Mem_DataIn = 32'h1F1F1F1F;
            tick();
            gap++;
        end
        bus.Mem_Ack = 1'b0;
        check("prio if_gap", 64'(gap), 64'd3);
        check("prio if_ack", 64'(bus.IF_Ack), 64'd1);
        check("prio if_data", 64'(bus.IF_DataOut), 64'h1F1F1F1F);
        check("prio if_addr", 64'(bad), 64'd0);
        bus.IF_Read = 1'b0;
        tick();

        // Continuous IF_Read with zero-wait memory: one access per 3 cycles
        clear_inputs();
        bus.IF_Read    = 1'b1;
        bus.IF_Address = 30'h0000010;
        bus.Mem_DataIn = 32'h24210001;
        ack_cnt  = 0;
        req_cnt  = 0;
        dup_bad  = 0;
        prev_ack = 1'b0;
        for (int i = 0; i < 9; i++) begin
            bus.Mem_Ack = bus.Mem_Req;
            tick();
            if (bus.Mem_Req === 1'b1) req_cnt++;
            if (bus.IF_Ack === 1'b1) ack_cnt++;
            if (prev_ack && bus.Mem_Req !== 1'b0) dup_bad++;
            if (bus.IF_Ack === 1'b1 && bus.Mem_Req !== 1'b0) dup_bad++;
            prev_ack = bus.IF_Ack;
        end
        bus.IF_Read = 1'b0;
        bus.Mem_Ack = 1'b0;
        check("stream acks", 64'(ack_cnt), 64'd3);
        check("stream reqs", 64'(req_cnt), 64'd3);
        check("stream no_dup", 64'(dup_bad), 64'd0);
        tick();
        check("stream idle", 64'(dbg_state), 64'(IDLE));

        // Reset asserted mid-cycle during D_BUSY
        clear_inputs();
        bus.D_Read    = 1'b1;
        bus.D_Address = 30'h0000077;
        tick();
        check("rstmid busy", 64'(dbg_state), 64'(D_BUSY));
        #3 reset = 1'b1;
        bus.D_Read     = 1'b0;
        bus.Mem_Ack    = 1'b1;
        bus.Mem_DataIn = 32'h99999999;
        #1;
        check("rstmid req_async", 64'(bus.Mem_Req), 64'd0);
        bad = 0;
        tick();
        if (bus.D_Ack !== 1'b0) bad++;
        #2 reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            bus.Mem_Ack = 1'b0;
            if (bus.D_Ack !== 1'b0 || bus.Mem_Req !== 1'b0) bad++;
        end
        check("rstmid no_ack", 64'(bad), 64'd0);
        check("rstmid idle", 64'(dbg_state), 64'(IDLE));
        check("rstmid d_data", 64'(bus.D_DataOut), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory bus between instruction fetch (IF) and data access (MEM stage).
- Sequences each access as request -> grant -> memory ack -> one-cycle requester ack.
- Supplies the data-side stall level that the hazard logic consumes as its memory-controller stall input.
- Sits between the IF/MEM pipeline stages and the external memory interface.

Parameters:
- ADDR_W, 30, word-address width (byte offset stripped).
- DATA_W, 32, data width; byte-enable width is DATA_W/8.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- IF_Read  in  1  instruction read request; held by the requester until IF_Ack.
- IF_Address  in  ADDR_W  instruction word address.
- IF_DataOut  out  DATA_W  fetched instruction; valid while IF_Ack=1.
- IF_Ack  out  1  one-cycle completion pulse for the IF side.
- D_Read  in  1  data read request; held until D_Ack.
- D_Write  in  DATA_W/8  store byte enables; nonzero means write; held until D_Ack.
- D_Address  in  ADDR_W  data word address.
- D_DataIn  in  DATA_W  store data.
- D_DataOut  out  DATA_W  load data; valid while D_Ack=1.
- D_Ack  out  1  one-cycle completion pulse for the data side.
- DataMemStall  out  1  combinational: (D_Read | (D_Write != 0)) & ~D_Ack.
- Mem_Req  out  1  memory request; held until Mem_Ack.
- Mem_We  out  DATA_W/8  byte write enables to memory.
- Mem_Address  out  ADDR_W  memory word address.
- Mem_DataOut  out  DATA_W  write data to memory.
- Mem_DataIn  in  DATA_W  read data from memory; sampled when Mem_Ack=1.
- Mem_Ack  in  1  memory completion; one cycle; may arrive in the first Mem_Req cycle.

Behaviour:
- Reset values:
  - state IDLE.
  - Mem_Req=0, Mem_We=0, Mem_Address=0, Mem_DataOut=0.
  - IF_Ack=0, D_Ack=0, IF_DataOut=0, D_DataOut=0.
  - Reset applies immediately, not at the next clock edge.
- FSM states: IDLE, I_BUSY, D_BUSY, DONE.
- IDLE:
  - Data request pending -> D_BUSY. Data side has fixed priority because MEM holds the older instruction.
  - Else IF_Read -> I_BUSY.
  - Else stay in IDLE.
  - On the transition edge, register address, byte enables and write data into the Mem_* outputs.
  - For I_BUSY: Mem_We=0.
  - For D_BUSY: Mem_We=D_Write. If D_Read and D_Write are both set, the access is a write and read data is still returned.
- I_BUSY / D_BUSY:
  - Mem_Req=1 with all Mem_* outputs stable until Mem_Ack.
  - No preemption.
  - Requests from the other side are left pending.
- On Mem_Ack in a BUSY state (next edge):
  - Capture Mem_DataIn into IF_DataOut or D_DataOut.
  - Assert the matching Ack for exactly one cycle.
  - Mem_Req=0, Mem_We=0.
  - Go to DONE.
- DONE:
  - All requests are ignored for one cycle. The requester sees Ack and drops its request, so there is no duplicate access.
  - Next edge: IDLE.
  - Ack deasserts.
- Latency, request seen in IDLE at edge k:
  - Mem_Req high at k+1.
  - Mem_Ack sampled at edge k+1+w (w = memory wait cycles, w >= 0).
  - Ack high the following cycle.
  - Minimum 3 cycles request-to-idle; back-to-back accesses every 3+w cycles.
- Mem_Ack outside a BUSY state is ignored. This includes IDLE, DONE and the cycle after reset.
- Requester deasserting its request mid-access is not supported. The access completes and Ack still pulses.
- Reset mid-access:
  - Mem_Req drops asynchronously.
  - No Ack is issued and captured data is discarded.
  - Memory must tolerate the abandoned request.
- Ack output registers hold their data value until the next capture. Only the Ack pulse qualifies validity.

Decomposition:
- Shared package mem_arb_pkg holds:
  - enum arb_state_t {IDLE, I_BUSY, D_BUSY, DONE};
  - enum arb_owner_t {OWN_I, OWN_D};
  - defaults ADDR_W=30 and DATA_W=32.
- No sub-module: the FSM and a single address/data register bank fit in one module of about 150-200 lines.

Test Plan:
- IF_Read=1 with IF_Address=0x0000100, memory w=2 returning 0x8C220004:
  - Mem_Req high for 3 cycles with Mem_We=0.
  - IF_Ack one pulse with IF_DataOut=0x8C220004.
  - Exactly one Mem_Req burst.
- IF_Read and D_Read asserted in the same cycle, w=0:
  - D access granted first; D_Ack pulses.
  - After DONE, IF access granted; IF_Ack pulses 3 cycles after D_Ack.
- Store with D_Write=4'b0011, D_Address=0x40, D_DataIn=0xDEADBEEF:
  - Mem_We=0011, Mem_Address=0x40, Mem_DataOut=0xDEADBEEF.
  - DataMemStall=1 until the D_Ack cycle, then 0.
- Zero-wait memory (Mem_Ack in first Mem_Req cycle) with continuous IF_Read:
  - One access per 3 cycles.
  - No second Mem_Req during DONE.
- Reset asserted mid-cycle during D_BUSY:
  - Mem_Req=0 before the next clock edge.
  - D_Ack never pulses; state IDLE after release.
- Spurious Mem_Ack=1 while IDLE with no requests:
  - No Ack output, no state change, all Mem_* outputs stay 0.
